// File: rtl/cia_pipe_adder.sv
// cia_pipe_adder: pipelined carry-increment adder/subtractor with a valid/ready stream interface
//
// Each SEG-bit segment precomputes a zero-carry sum and an incremented sum. The
// inter-segment carry then picks one of the two. The result sits in a registered
// output slot that is held under backpressure.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational from out_ready)
//   a, b                  WIDTH-bit operands
//   carry_in              carry into bit 0, ignored when sub=1
//   sub                   0: a+b+carry_in, 1: a-b (a+~b+1)
//   out_valid / out_ready result beat handshake
//   sum                   WIDTH-bit result, modulo 2^WIDTH
//   carry_out             carry out of the MSB (1 = no borrow when subtracting)
//   overflow              signed two's-complement overflow
//
// Build option CIA_MID_REG_EN: adds a register slot after the segment adders.
// This gives 2-cycle latency and two slots of buffering. Without it, latency is
// 1 cycle with a single slot.
module cia_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NSEG = WIDTH / SEG;

    logic [WIDTH-1:0] bx;
    logic             cx;
    assign bx = sub ? ~b : b;
    assign cx = sub | carry_in;

    logic [NSEG-1:0][SEG-1:0] s0_w, s1_w;
    logic [NSEG-1:0]          c0_w, c1_w;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SEG:0] t;
        assign t       = {1'b0, a[k*SEG +: SEG]} + {1'b0, bx[k*SEG +: SEG]};
        assign s0_w[k] = t[SEG-1:0];
        assign s1_w[k] = t[SEG-1:0] + SEG'(1);
        assign c0_w[k] = t[SEG];
        // An incoming carry propagates through an all-ones segment
        assign c1_w[k] = t[SEG] | (&t[SEG-1:0]);
    end

    // Carry-chain inputs: taken straight from the segment adders, or from the mid register
    logic [NSEG-1:0][SEG-1:0] ch_s0, ch_s1;
    logic [NSEG-1:0]          ch_c0, ch_c1;
    logic                     ch_cx, ch_amsb, ch_bmsb;
    logic [WIDTH-1:0]         ch_sum;
    logic                     ch_co, carry, ch_ov;

    always_comb begin
        ch_sum = '0;
        carry  = ch_cx;
        for (int i = 0; i < NSEG; i++) begin
            ch_sum[i*SEG +: SEG] = carry ? ch_s1[i] : ch_s0[i];
            carry                = carry ? ch_c1[i] : ch_c0[i];
        end
        ch_co = carry;
    end

    assign ch_ov = (ch_amsb == ch_bmsb) & (ch_sum[WIDTH-1] != ch_amsb);

    // Output slot
    logic             out_load, vo_q, vo_d, co_q, ov_q;
    logic [WIDTH-1:0] sum_q;

    assign vo_d = out_load | (vo_q & ~out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vo_q  <= 1'b0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            vo_q <= vo_d;
            if (out_load) begin
                sum_q <= ch_sum;
                co_q  <= ch_co;
                ov_q  <= ch_ov;
            end
        end
    end

`ifdef CIA_MID_REG_EN
    logic                     v1_q, v1_d, in_load, cx_q, amsb_q, bmsb_q;
    logic [NSEG-1:0][SEG-1:0] s0_q, s1_q;
    logic [NSEG-1:0]          c0_q, c1_q;

    assign out_load = v1_q & (~vo_q | out_ready);
    assign in_ready = ~v1_q | out_load;
    assign in_load  = in_valid & in_ready;
    assign v1_d     = in_load | (v1_q & ~out_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            s0_q   <= '0;
            s1_q   <= '0;
            c0_q   <= '0;
            c1_q   <= '0;
            cx_q   <= 1'b0;
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (in_load) begin
                s0_q   <= s0_w;
                s1_q   <= s1_w;
                c0_q   <= c0_w;
                c1_q   <= c1_w;
                cx_q   <= cx;
                amsb_q <= a[WIDTH-1];
                bmsb_q <= bx[WIDTH-1];
            end
        end
    end

    assign ch_s0   = s0_q;
    assign ch_s1   = s1_q;
    assign ch_c0   = c0_q;
    assign ch_c1   = c1_q;
    assign ch_cx   = cx_q;
    assign ch_amsb = amsb_q;
    assign ch_bmsb = bmsb_q;
`else
    assign in_ready = ~vo_q | out_ready;
    assign out_load = in_valid & in_ready;

    assign ch_s0   = s0_w;
    assign ch_s1   = s1_w;
    assign ch_c0   = c0_w;
    assign ch_c1   = c1_w;
    assign ch_cx   = cx;
    assign ch_amsb = a[WIDTH-1];
    assign ch_bmsb = bx[WIDTH-1];
`endif

    assign out_valid = vo_q;
    assign sum       = sum_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;

endmodule
